// File: rtl/store_merge_unit.sv
// store_merge_unit: sequential store path with sub-word read-modify-write merge.
// Misaligned or reserved-size requests are rejected with a one-cycle err pulse.
module store_merge_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done,
    output logic              err
);
    localparam int NB  = DATA_W / 8;
    localparam int OFF = $clog2(NB);
    localparam int CW  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    logic [2:0]        state;
    logic [CW-1:0]     cnt;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [OFF-1:0]    lane_q;
    logic [OFF-1:0]    lane;
    logic              misaligned;
    logic              full_width;
    int                nb_q;
    int                rel;
    logic [DATA_W-1:0] merged;

    assign lane       = req_addr[OFF-1:0];
    assign full_width = (req_size == 2'b00) && (NB == 4);

    always_comb begin
        unique case (req_size)
            2'b00:   misaligned = (lane[1:0] != 2'b00);
            2'b01:   misaligned = lane[0];
            2'b10:   misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        unique case (size_q)
            2'b00:   nb_q = 4;
            2'b01:   nb_q = 2;
            2'b10:   nb_q = 1;
            default: nb_q = 0;
        endcase
    end

    // Lanes lane_q .. lane_q+n-1 take B's low bytes; the rest keep read data.
    always_comb begin
        merged = mem_rdata;
        rel    = 0;
        for (int k = 0; k < NB; k++) begin
            rel = k - int'(lane_q);
            if (rel >= 0 && rel < nb_q) begin
                merged[8*k +: 8] = data_q[{rel[1:0], 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            data_q    <= '0;
            size_q    <= '0;
            lane_q    <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        data_q <= req_data;
                        size_q <= req_size;
                        lane_q <= lane;
                        if (misaligned) begin
                            state <= S_ERR;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:OFF], OFF'(0)};
                            if (full_width) begin
                                mem_wdata <= DATA_W'(req_data);
                                state     <= S_WR;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end
                end
                S_RD: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == CW'(RD_LAT - 1)) begin
                        mem_wdata <= merged;
                        state     <= S_WR;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state == S_IDLE);
    assign mem_rd    = (state == S_RD);
    assign mem_wr    = (state == S_WR);
    assign done      = (state == S_DONE);
    assign err       = (state == S_ERR);

endmodule
